mdu_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide unit in the single-cycle core.
- Accepts an MDU request from the controller, which is the existing `mdu_valid` / `mdu_op` decode.
- Runs an iterative shift-add multiply or restoring divide over a captured operand pair.
- Asserts a stall so the PC and register-file write hold until the result is ready; result feeds the MDU input of the writeback mux.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_seq_step.sv | 36 +++
 rtl/mdu_seq.sv | 154 +++++++++++++++
 tb/tb_mdu_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN_DEF-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEF-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;

endpackage

// File: rtl/mdu_seq_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide over {acc_hi, acc_lo}.
module mdu_seq_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    if (is_div) begin
      // Bit XLEN of diff is the borrow: set means the trial subtract failed, keep remainder.
      if (!diff[XLEN]) begin
        nxt_hi = diff[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with core stall.
// Define MDU_FAST_MUL_EN to resolve all multiplies in a single cycle at accept.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mdu_valid,
  input  logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            mdu_ready,
  output logic [XLEN-1:0] mdu_result,
  output logic            stall,
  output logic            busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  mdu_state_e        state;
  logic [2:0]        op_q;
  logic              sign_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [CNT_W-1:0]  cnt;

  logic              a_signed, b_signed, a_neg, b_neg, res_neg;
  logic              is_div, div_zero, sdiv_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [XLEN-1:0]   nxt_hi, nxt_lo, quo_rem, calc_res;
  logic [2*XLEN-1:0] prod_fix;

  // Accept-cycle decode straight off the live operands.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (mdu_op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    is_div      = mdu_op[2];
    a_neg       = a_signed & rs1[XLEN-1];
    b_neg       = b_signed & rs2[XLEN-1];
    a_mag       = a_neg ? -rs1 : rs1;
    b_mag       = b_neg ? -rs2 : rs2;
    res_neg     = (is_div & mdu_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = is_div && (rs2 == '0);
    sdiv_ovf    = (mdu_op == OP_DIV || mdu_op == OP_REM) && (rs1 == INT_MIN) && (rs2 == '1);
    special     = div_zero | sdiv_ovf;
    if (div_zero) special_res = mdu_op[1] ? rs1 : DIV0_Q;
    else          special_res = mdu_op[1] ? '0 : INT_MIN;
  end

`ifdef MDU_FAST_MUL_EN
  // 33x33 signed product; only the low 64 bits matter, so extend both to 64 and multiply.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_a    = {{XLEN{a_neg}}, rs1};
  assign fast_b    = {{XLEN{b_neg}}, rs2};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (mdu_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  mdu_seq_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div(op_q[2]),
    .acc_hi(acc_hi),
    .acc_lo(acc_lo),
    .opb   (b_q),
    .nxt_hi(nxt_hi),
    .nxt_lo(nxt_lo)
  );

  // Sign fix-up on the accumulators produced by the final iteration.
  always_comb begin
    prod_fix = sign_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
    quo_rem  = op_q[1] ? nxt_hi : nxt_lo;
    if (op_q[2])              calc_res = sign_q ? -quo_rem : quo_rem;
    else if (op_q == OP_MUL)  calc_res = prod_fix[XLEN-1:0];
    else                      calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      sign_q     <= 1'b0;
      b_q        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      cnt        <= '0;
      mdu_ready  <= 1'b0;
      mdu_result <= '0;
    end else begin
      mdu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mdu_valid) begin
            op_q   <= mdu_op;
            sign_q <= res_neg;
            b_q    <= b_mag;
            acc_hi <= '0;
            acc_lo <= a_mag;
            cnt    <= '0;
            if (special) begin
              state      <= DONE;
              mdu_ready  <= 1'b1;
              mdu_result <= special_res;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!is_div) begin
              state      <= DONE;
              mdu_ready  <= 1'b1;
              mdu_result <= fast_res;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!mdu_valid) begin
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              state      <= DONE;
              mdu_ready  <= 1'b1;
              mdu_result <= calc_res;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = mdu_valid & ~mdu_ready;
  assign busy  = (state == CALC);

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised scoreboard bench for mdu_seq against a plain-arithmetic RV32M model.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdu_valid;
  logic [2:0]  mdu_op;
  logic [31:0] rs1, rs2;
  logic        mdu_ready;
  logic [31:0] mdu_result;
  logic        stall;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [2:0]  op;
  } exp_t;
  exp_t exp_q[$];

  mdu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .mdu_valid (mdu_valid),
    .mdu_op    (mdu_op),
    .rs1       (rs1),
    .rs2       (rs2),
    .mdu_ready (mdu_ready),
    .mdu_result(mdu_result),
    .stall     (stall),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && mdu_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("result_op%0d", e.op), mdu_result, e.res);
        chk("ready_cycle", cyc, e.due);
        chk("busy_at_ready", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following the ready cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int  n;
    logic stall_bad;
    exp_t e;
    mdu_valid = 1'b1;
    mdu_op    = op;
    rs1       = a;
    rs2       = b;
    e.res = ref_mdu(op, a, b);
    e.due = cyc + exp_lat(op, a, b);
    e.op  = op;
    exp_q.push_back(e);
    last_res  = e.res;
    n         = 0;
    stall_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (mdu_ready) break;
      if (!stall) stall_bad = 1'b1;
      n++;
      if (n > 40) begin
        chk("ready_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
      rs1 = $urandom;  // must be ignored after accept
      rs2 = $urandom;
      mdu_op = 3'($urandom);
    end
    chk("stall_hold", {31'b0, stall_bad}, 32'd0);
    chk("stall_at_ready", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    mdu_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst       = 1'b0;
    mdu_valid = 1'b0;
    mdu_op    = 3'b000;
    rs1       = '0;
    rs2       = '0;
    #1;
    chk("rst_ready", {31'b0, mdu_ready}, 32'd0);
    chk("rst_result", mdu_result, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2);
    run_op(3'b101, 32'd100, 32'd7);
    run_op(3'b111, 32'd100, 32'd7);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b100, 32'd5, 32'd0);
    run_op(3'b110, 32'd5, 32'd0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000);

    // Abort: drop mdu_valid in the tenth cycle after accept.
    mdu_valid = 1'b1;
    mdu_op    = 3'b101;
    rs1       = $urandom;
    rs2       = $urandom_range(1, 1000);
    repeat (10) begin @(posedge clk); #1; end
    mdu_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("abort_busy_after", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, mdu_ready}, 32'd0);
    chk("abort_result_kept", mdu_result, last_res);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a divide.
    mdu_valid = 1'b1;
    mdu_op    = 3'b101;
    rs1       = 32'd1000;
    rs2       = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, mdu_ready}, 32'd0);
    chk("midrst_result", mdu_result, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    mdu_valid = 1'b0;
    @(posedge clk); #1;
    run_op(3'b101, 32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), pick(), pick());
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
